mod_inv_829: RTL and testbench

- Sequential modular inverter over Z_829. Computes a^-1 = a^827 mod 829 (Fermat) using left-to-right square-and-multiply.
- Every intermediate product is reduced back into [0,828] by an internal Barrett-style reduction stage.
- Sits beside the mod-829 reduction datapath. It supplies the inverse direction of modular multiplication, for normalisation and division steps in the field pipeline.
- Single-operation-in-flight, valid/ready on both sides.

---
 rtl/mod_inv_829.sv | 147 ++++++++++++++
 tb/tb_mod_inv_829.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mod_inv_829.sv
// Constant-time modular inverter over Z_829. It computes a^827 mod 829 by left-to-right
// square-and-multiply, with one Barrett-reduced modular multiply per cycle.
module mod_inv_829 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [9:0] din_a,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [9:0] dout_r,
    output logic       dout_err
);

    localparam logic [9:0]  Q        = 10'd829;
    localparam logic [20:0] MU       = 21'd1264;
    localparam logic [15:0] EXP_BITS = 16'd827;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SQR  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // The Barrett quotient estimate undershoots by at most two, so two corrections suffice.
    function automatic logic [9:0] modmul(input logic [9:0] x, input logic [9:0] y);
        logic [19:0] p;
        logic [20:0] m;
        logic [20:0] t;
        logic [20:0] r0;
        logic [20:0] r1;
        p  = {10'd0, x} * {10'd0, y};
        m  = {10'd0, p[19:9]} * MU;
        t  = m >> 11;
        r0 = {1'b0, p} - t * {11'd0, Q};
        r1 = (r0 >= {11'd0, Q}) ? (r0 - {11'd0, Q}) : r0;
        return (r1 >= {11'd0, Q}) ? (r1[9:0] - Q) : r1[9:0];
    endfunction

    logic [1:0] state_q, state_d;
    logic [9:0] acc_q, acc_d;
    logic [9:0] base_q, base_d;
    logic [3:0] idx_q, idx_d;
    logic       err_q, err_d;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [9:0] dout_r_q, dout_r_d;
    logic       dout_err_q, dout_err_d;
    logic [9:0] a_red_s;
    logic [9:0] prod_s;

    assign a_red_s = (din_a >= Q) ? (din_a - Q) : din_a;
    assign prod_s  = modmul(acc_q, (state_q == MUL) ? base_q : acc_q);

    // Next-state logic for the exponentiation sequencer and registered outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        idx_d       = idx_q;
        err_d       = err_q;
        dout_r_d    = dout_r_q;
        dout_err_d  = dout_err_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    base_d  = a_red_s;
                    acc_d   = a_red_s;
                    idx_d   = 4'd8;
                    err_d   = (a_red_s == 10'd0);
                    state_d = SQR;
                end else begin
                    state_d = IDLE;
                end
            end
            SQR: begin
                acc_d = prod_s;
                if (EXP_BITS[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            MUL: begin
                acc_d = prod_s;
                if (idx_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 4'd1;
                    state_d = SQR;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        // Results are captured once, on entry to DONE, and held until the next entry.
        if ((state_d == DONE) && (state_q != DONE)) begin
            dout_r_d   = acc_d;
            dout_err_d = err_d;
        end else begin
            dout_r_d   = dout_r_q;
            dout_err_d = dout_err_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= 10'd0;
            base_q      <= 10'd0;
            idx_q       <= 4'd0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            dout_r_q    <= 10'd0;
            dout_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dout_r_q    <= dout_r_d;
            dout_err_q  <= dout_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout_r    = dout_r_q;
    assign dout_err  = dout_err_q;

endmodule

// File: tb/tb_mod_inv_829.sv
// Self-checking bench for mod_inv_829: directed corner operands, back-pressure, mid-operation
// reset, random operands and a full sweep, all checked against a brute-force inverse model.
module tb_mod_inv_829;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] din_a;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] dout_r;
    logic       dout_err;

    int n_pass;
    int n_total;

    mod_inv_829 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din_a    (din_a),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dout_r   (dout_r),
        .dout_err (dout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reduce mod 829, then search for the multiplicative inverse.
    function automatic int inv_model(input int a);
        int ar;
        ar = a % 829;
        if (ar == 0) return 0;
        for (int b = 1; b < 829; b++) begin
            if ((ar * b) % 829 == 1) return b;
        end
        return -1;
    endfunction

    // Drive one operand, wait for the result, then complete the output handshake.
    task automatic do_op(input logic [9:0] a, output int lat, output logic [9:0] r, output logic e);
        logic rdy;
        bit   acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        din_a    = a;
        for (int i = 0; i < 100; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        din_a    = 10'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!acc) lat = 999;
        r = dout_r;
        e = dout_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din_a = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout_r !== 10'd0 || dout_err !== 1'b0)
            $display("FAIL reset_state: rdy=%b vld=%b r=%0d err=%b, required 0 0 0 0",
                     in_ready, out_valid, dout_r, dout_err);
        else n_pass++;
        rst_n = 1'b1;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b, required 0", in_ready);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_release: got %b, required 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_directed();
        int         vals[8] = '{2, 3, 1, 828, 830, 1023, 0, 829};
        int         lat;
        logic [9:0] r;
        logic       e;
        int         exp_r;
        for (int i = 0; i < 8; i++) begin
            do_op(10'(vals[i]), lat, r, e);
            exp_r = inv_model(vals[i]);
            n_total++;
            if (lat !== 15) $display("FAIL latency_%0d: got %0d, required 15", vals[i], lat);
            else n_pass++;
            n_total++;
            if (int'(r) !== exp_r || e !== (vals[i] % 829 == 0))
                $display("FAIL result_%0d: got r=%0d err=%b, required r=%0d err=%b",
                         vals[i], r, e, exp_r, (vals[i] % 829 == 0));
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] a;
        logic [9:0] nxt;
        int         lat;
        a   = 10'($urandom_range(1, 828));
        nxt = 10'($urandom_range(1, 828));
        in_valid = 1'b1; din_a = a;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat !== 15) $display("FAIL bp_latency: got %0d, required 15", lat);
        else n_pass++;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            din_a    = 10'($urandom);
            @(posedge clk); #1;
            n_total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || int'(dout_r) !== inv_model(a))
                $display("FAIL bp_hold_%0d: vld=%b rdy=%b r=%0d, required 1 0 %0d",
                         c, out_valid, in_ready, dout_r, inv_model(a));
            else n_pass++;
        end
        in_valid = 1'b1; din_a = nxt; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_next_accept: rdy=%b, required 0", in_ready);
        else n_pass++;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_total++;
        if (lat !== 15 || int'(dout_r) !== inv_model(nxt))
            $display("FAIL bp_next_result: lat=%0d r=%0d, required 15 %0d", lat, dout_r, inv_model(nxt));
        else n_pass++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [9:0] r;
        logic       e;
        in_valid = 1'b1; din_a = 10'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dout_r !== 10'd0 || dout_err !== 1'b0)
            $display("FAIL mid_reset: rdy=%b vld=%b r=%0d err=%b, required 0 0 0 0",
                     in_ready, out_valid, dout_r, dout_err);
        else n_pass++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(10'd2, lat, r, e);
        n_total++;
        if (lat !== 15 || r !== 10'd415 || e !== 1'b0)
            $display("FAIL after_reset_op: lat=%0d r=%0d err=%b, required 15 415 0", lat, r, e);
        else n_pass++;
    endtask

    task automatic test_random();
        int         a;
        int         lat;
        logic [9:0] r;
        logic       e;
        for (int i = 0; i < 40; i++) begin
            a = int'($urandom_range(0, 1023));
            do_op(10'(a), lat, r, e);
            n_total++;
            if (lat !== 15 || int'(r) !== inv_model(a) || e !== (a % 829 == 0))
                $display("FAIL random_%0d: lat=%0d r=%0d err=%b, required 15 %0d %b",
                         a, lat, r, e, inv_model(a), (a % 829 == 0));
            else n_pass++;
        end
    endtask

    task automatic test_sweep();
        int         lat;
        logic [9:0] r;
        logic       e;
        for (int a = 1; a < 829; a++) begin
            do_op(10'(a), lat, r, e);
            n_total++;
            if (lat !== 15 || (a * int'(r)) % 829 !== 1 || e !== 1'b0)
                $display("FAIL sweep_%0d: lat=%0d r=%0d err=%b, required 15, a*r mod 829 = 1, err 0",
                         a, lat, r, e);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
